// File: rtl/lcd_resp_pkg.sv
// lcd_resp_pkg: shared opcodes, address-counter wrap points and FSM states for the LCD responder
package lcd_resp_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_BUSY} state_t;
    localparam logic [7:0] SPACE       = 8'h20;
    localparam logic [6:0] AC_L0_FIRST = 7'h00;
    localparam logic [6:0] AC_L0_LAST  = 7'h27;
    localparam logic [6:0] AC_L1_FIRST = 7'h40;
    localparam logic [6:0] AC_L1_LAST  = 7'h67;
    localparam logic [7:0] OP_SET_DD   = 8'h80;
    localparam logic [7:0] OP_SET_CG   = 8'h40;
    localparam logic [7:0] OP_FUNC     = 8'h20;
    localparam logic [7:0] OP_SHIFT    = 8'h10;
    localparam logic [7:0] OP_DISP     = 8'h08;
    localparam logic [7:0] OP_ENTRY    = 8'h04;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_CLEAR    = 8'h01;
    // True when op is the highest set bit of d.
    function automatic logic is_op(input logic [7:0] d, input logic [7:0] op);
        return (d & ~(op - 8'd1)) == op;
    endfunction
endpackage

// File: rtl/lcd_ac_map.sv
// lcd_ac_map: maps the address counter onto the 16x2 shadow and steps it with line wrap.
// Shared with the LCD driver side.
module lcd_ac_map
    import lcd_resp_pkg::*;
(
    input  logic [6:0] i_ac,
    input  logic       i_inc,
    output logic       o_valid,
    output logic [4:0] o_idx,
    output logic [6:0] o_next
);
    assign o_valid = (i_ac[5:4] == 2'b00);
    assign o_idx   = {i_ac[6], i_ac[3:0]};
    assign o_next  = i_inc
        ? ((i_ac == AC_L0_LAST) ? AC_L1_FIRST : (i_ac == AC_L1_LAST) ? AC_L0_FIRST : i_ac + 7'd1)
        : ((i_ac == AC_L1_FIRST) ? AC_L0_LAST : (i_ac == AC_L0_FIRST) ? AC_L1_LAST : i_ac - 7'd1);
endmodule

// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-style display-side bus responder with 16x2 DDRAM shadow and busy model.
// Define LCD_RESP_CGRAM_EN to add a 64x8 CGRAM and CG addressing mode.
module lcd_responder
    import lcd_resp_pkg::*;
#(
    parameter int BUSY_CMD = 2000,
    parameter int BUSY_CLR = 82000
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic       overrun,
    output logic       disp_on,
    input  logic [4:0] dbg_addr,
    output logic [7:0] dbg_char
);
    localparam int CW = $clog2((BUSY_CLR > BUSY_CMD ? BUSY_CLR : BUSY_CMD) + 1);

    logic [10:0] r_sync1, r_sync2, r_prev;
    state_t      r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [4:0]  r_fill, w_fill_nxt;
    logic [6:0]  r_ac, w_ac_nxt, w_ac_step, w_status;
    logic        r_id, w_id_nxt, r_disp, w_disp_nxt, r_overrun;
    logic [7:0]  r_shadow [32];
    logic [7:0]  r_dbg, w_rdata;
    logic        w_valid, w_dir, w_fall, w_rs, w_rw, w_dd_wr;
    logic        w_go_cmd, w_go_home, w_go_clr;
    logic [4:0]  w_idx;
    logic [7:0]  w_d;

    // Bus signals are asynchronous; a transfer uses the values seen just before EN fell.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= {lcd_en, lcd_rs, lcd_rw, lcd_data_in};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall = r_prev[10] & ~r_sync2[10];
    assign w_rs   = r_prev[9];
    assign w_rw   = r_prev[8];
    assign w_d    = r_prev[7:0];
    assign w_dir  = w_rs ? r_id : w_d[2];

    lcd_ac_map u_map (
        .i_ac   (r_ac),
        .i_inc  (w_dir),
        .o_valid(w_valid),
        .o_idx  (w_idx),
        .o_next (w_ac_step)
    );

`ifdef LCD_RESP_CGRAM_EN
    logic       r_cg, w_cg_nxt, w_cg_wr;
    logic [5:0] r_cga, w_cga_nxt;
    logic [7:0] r_cgram [64];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cg  <= 1'b0;
            r_cga <= '0;
            for (int i = 0; i < 64; i++) r_cgram[i] <= 8'h00;
        end else begin
            r_cg  <= w_cg_nxt;
            r_cga <= w_cga_nxt;
            if (w_cg_wr) r_cgram[r_cga] <= w_d;
        end
    end
    assign w_status = r_cg ? {1'b0, r_cga} : r_ac;
    assign w_rdata  = r_cg ? r_cgram[r_cga] : (w_valid ? r_shadow[w_idx] : SPACE);
`else
    assign w_status = r_ac;
    assign w_rdata  = w_valid ? r_shadow[w_idx] : SPACE;
`endif

    always_comb begin
        w_ac_nxt   = r_ac;
        w_id_nxt   = r_id;
        w_disp_nxt = r_disp;
        w_dd_wr    = 1'b0;
        w_go_cmd   = 1'b0;
        w_go_home  = 1'b0;
        w_go_clr   = 1'b0;
`ifdef LCD_RESP_CGRAM_EN
        w_cg_nxt   = r_cg;
        w_cga_nxt  = r_cga;
        w_cg_wr    = 1'b0;
`endif
        if (w_fall && w_rw && w_rs) begin
`ifdef LCD_RESP_CGRAM_EN
            if (r_cg) w_cga_nxt = r_id ? r_cga + 6'd1 : r_cga - 6'd1; else
`endif
            w_ac_nxt = w_ac_step;
        end else if (w_fall && !w_rw && r_state == ST_IDLE) begin
            if (w_rs) begin
                w_go_cmd = 1'b1;
`ifdef LCD_RESP_CGRAM_EN
                if (r_cg) begin
                    w_cg_wr   = 1'b1;
                    w_cga_nxt = r_id ? r_cga + 6'd1 : r_cga - 6'd1;
                end else
`endif
                begin
                    w_dd_wr  = w_valid;
                    w_ac_nxt = w_ac_step;
                end
            end else if (is_op(w_d, OP_SET_DD)) begin
                w_go_cmd = 1'b1;
                w_ac_nxt = w_d[6:0];
`ifdef LCD_RESP_CGRAM_EN
                w_cg_nxt = 1'b0;
`endif
            end else if (is_op(w_d, OP_SET_CG)) begin
                w_go_cmd = 1'b1;
`ifdef LCD_RESP_CGRAM_EN
                w_cg_nxt  = 1'b1;
                w_cga_nxt = w_d[5:0];
`endif
            end else if (is_op(w_d, OP_FUNC)) begin
                w_go_cmd = 1'b1;
            end else if (is_op(w_d, OP_SHIFT)) begin
                w_go_cmd = 1'b1;
                w_ac_nxt = w_d[3] ? r_ac : w_ac_step;
            end else if (is_op(w_d, OP_DISP)) begin
                w_go_cmd   = 1'b1;
                w_disp_nxt = w_d[2];
            end else if (is_op(w_d, OP_ENTRY)) begin
                w_go_cmd = 1'b1;
                w_id_nxt = w_d[1];
            end else if (is_op(w_d, OP_HOME)) begin
                w_go_home = 1'b1;
                w_ac_nxt  = AC_L0_FIRST;
            end else if (is_op(w_d, OP_CLEAR)) begin
                w_go_clr = 1'b1;
                w_ac_nxt = AC_L0_FIRST;
                w_id_nxt = 1'b1;
            end
        end
    end

    // The busy counter keeps running through FILL so clear totals BUSY_CLR cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fill_nxt  = r_fill;
        case (r_state)
            ST_IDLE: begin
                if (w_go_clr) begin
                    w_state_nxt = ST_FILL;
                    w_cnt_nxt   = CW'(BUSY_CLR - 1);
                    w_fill_nxt  = '0;
                end else if (w_go_home) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = CW'(BUSY_CLR - 1);
                end else if (w_go_cmd) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = CW'(BUSY_CMD - 1);
                end
            end
            ST_FILL: begin
                w_cnt_nxt   = r_cnt - CW'(1);
                w_fill_nxt  = r_fill + 5'd1;
                w_state_nxt = (r_fill == 5'd31) ? ST_BUSY : ST_FILL;
            end
            ST_BUSY: begin
                w_cnt_nxt   = r_cnt - CW'(1);
                w_state_nxt = (r_cnt == '0) ? ST_IDLE : ST_BUSY;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ac      <= AC_L0_FIRST;
            r_id      <= 1'b1;
            r_disp    <= 1'b0;
            r_overrun <= 1'b0;
            r_dbg     <= SPACE;
            for (int i = 0; i < 32; i++) r_shadow[i] <= SPACE;
        end else begin
            r_ac   <= w_ac_nxt;
            r_id   <= w_id_nxt;
            r_disp <= w_disp_nxt;
            r_dbg  <= r_shadow[dbg_addr];
            if (w_fall && !w_rw && r_state != ST_IDLE) r_overrun <= 1'b1;
            if (r_state == ST_FILL) r_shadow[r_fill] <= SPACE;
            else if (w_dd_wr) r_shadow[w_idx] <= w_d;
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign overrun      = r_overrun;
    assign disp_on      = r_disp;
    assign dbg_char     = r_dbg;
    assign lcd_data_oe  = r_sync2[10] & r_sync2[8];
    assign lcd_data_out = lcd_data_oe ? (r_sync2[9] ? w_rdata : {busy, w_status}) : 8'h00;
endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: scoreboard bench for lcd_responder (short busy timings).
// Exercises the CGRAM path too when LCD_RESP_CGRAM_EN is defined.
module tb_lcd_responder;
    localparam int BUSY_CMD = 16;
    localparam int BUSY_CLR = 48;

    logic       clock = 1'b0, reset = 1'b1;
    logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [4:0] dbg_addr = 5'd0;
    logic [7:0] lcd_data_out, dbg_char;
    logic       lcd_data_oe, busy, overrun, disp_on;

    lcd_responder #(.BUSY_CMD(BUSY_CMD), .BUSY_CLR(BUSY_CLR)) dut (
        .clock       (clock),
        .reset       (reset),
        .lcd_en      (lcd_en),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_data_in (lcd_data_in),
        .lcd_data_out(lcd_data_out),
        .lcd_data_oe (lcd_data_oe),
        .busy        (busy),
        .overrun     (overrun),
        .disp_on     (disp_on),
        .dbg_addr    (dbg_addr),
        .dbg_char    (dbg_char)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];
    int  n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_q.push_back('{tag, exp});
    endtask

    task automatic sb_pop(input logic [31:0] got);
        sb_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check(e.tag, got, e.exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_hi(input logic rs, input logic rw, input logic [7:0] d);
        lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_en = 1'b1;
        tick(4);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 1000) begin tick(1); k++; end
        if (k == 1000) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        bus_hi(rs, 1'b0, d);
        lcd_en = 1'b0;
        tick(4);
        wait_idle();
    endtask

    task automatic wr_busy(input logic rs, input logic [7:0] d, input int exp_len);
        int k = 0, n = 0;
        sb_push($sformatf("busy_len_%02h", d), 32'(exp_len));
        bus_hi(rs, 1'b0, d);
        lcd_en = 1'b0;
        while (!busy && k < 10) begin tick(1); k++; end
        while (busy && n < 500) begin tick(1); n++; end
        sb_pop(32'(n));
    endtask

    task automatic rd(input logic rs, input string tag, input logic [7:0] exp);
        sb_push(tag, 32'(exp));
        bus_hi(rs, 1'b1, 8'h00);
        check({tag, "_oe"}, 32'(lcd_data_oe), 32'd1);
        sb_pop(32'(lcd_data_out));
        lcd_en = 1'b0;
        tick(4);
    endtask

    task automatic dbg(input logic [4:0] a, input logic [7:0] exp);
        sb_push($sformatf("dbg_%02h", a), 32'(exp));
        dbg_addr = a;
        tick(1);
        sb_pop(32'(dbg_char));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_disp_on", 32'(disp_on), 32'd0);
        check("rst_oe", 32'(lcd_data_oe), 32'd0);
        check("rst_data_out", 32'(lcd_data_out), 32'd0);
        check("rst_dbg", 32'(dbg_char), 32'h20);
        reset = 1'b0;
        tick(2);

        wr_busy(1'b1, 8'h48, BUSY_CMD);
        dbg(5'h00, 8'h48);
        rd(1'b0, "status_after_H", 8'h01);

        wr(1'b0, 8'hC5);
        wr(1'b1, 8'h41);
        dbg(5'h15, 8'h41);
        rd(1'b0, "status_46", 8'h46);

        wr_busy(1'b0, 8'h01, BUSY_CLR);
        for (int i = 0; i < 32; i++) dbg(5'(i), 8'h20);
        rd(1'b0, "status_clear", 8'h00);

        wr(1'b0, 8'hA7);
        wr(1'b1, 8'h55);
        rd(1'b0, "wrap_27_40", 8'h40);
        dbg(5'h07, 8'h20);
        wr(1'b0, 8'hE7);
        wr(1'b1, 8'h56);
        rd(1'b0, "wrap_67_00", 8'h00);
        dbg(5'h17, 8'h20);

        wr(1'b0, 8'h04);
        wr(1'b0, 8'h80);
        wr(1'b1, 8'h33);
        rd(1'b0, "wrap_00_67", 8'h67);
        dbg(5'h00, 8'h33);

        wr_busy(1'b0, 8'h02, BUSY_CLR);
        rd(1'b0, "status_home", 8'h00);

        wr(1'b0, 8'h06);
        wr(1'b0, 8'h80);
        check("overrun_pre", 32'(overrun), 32'd0);
        bus_hi(1'b1, 1'b0, 8'h61);
        lcd_en = 1'b0;
        tick(4);
        bus_hi(1'b1, 1'b0, 8'h62);
        lcd_en = 1'b0;
        tick(4);
        check("overrun_set", 32'(overrun), 32'd1);
        wait_idle();
        dbg(5'h00, 8'h61);
        dbg(5'h01, 8'h20);
        rd(1'b0, "status_after_overrun", 8'h01);

        bus_hi(1'b1, 1'b0, 8'h62);
        lcd_en = 1'b0;
        tick(4);
        rd(1'b0, "status_busy", 8'h82);
        wait_idle();
        dbg(5'h01, 8'h62);

        wr(1'b0, 8'h10);
        rd(1'b0, "cursor_left", 8'h01);
        wr(1'b0, 8'h14);
        rd(1'b0, "cursor_right", 8'h02);

        wr(1'b0, 8'h0C);
        check("disp_on_set", 32'(disp_on), 32'd1);
        wr(1'b0, 8'h08);
        check("disp_on_clr", 32'(disp_on), 32'd0);

        wr_busy(1'b0, 8'h38, BUSY_CMD);
        rd(1'b0, "status_funcset", 8'h02);

        wr(1'b0, 8'h80);
        rd(1'b1, "data_read", 8'h61);
        rd(1'b0, "status_data_read", 8'h01);
        wr(1'b0, 8'hA0);
        rd(1'b1, "data_unmapped", 8'h20);

`ifdef LCD_RESP_CGRAM_EN
        wr(1'b0, 8'h48);
        wr(1'b1, 8'h1F);
        rd(1'b0, "status_cg", 8'h09);
        wr(1'b0, 8'h48);
        rd(1'b1, "cgram_8", 8'h1F);
        wr(1'b0, 8'h80);
        rd(1'b0, "status_dd_back", 8'h00);
`else
        wr_busy(1'b0, 8'h48, BUSY_CMD);
        rd(1'b0, "status_cg_ignored", 8'h21);
`endif

        wr(1'b0, 8'hCF);
        wr(1'b1, 8'h5A);
        dbg(5'h1F, 8'h5A);
        bus_hi(1'b0, 1'b0, 8'h01);
        lcd_en = 1'b0;
        begin
            int k = 0;
            while (!busy && k < 10) begin tick(1); k++; end
        end
        tick(5);
        #2 reset = 1'b1;
        @(negedge clock);
        check("midfill_busy", 32'(busy), 32'd0);
        check("midfill_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        dbg(5'h1F, 8'h20);
        dbg(5'h00, 8'h20);
        rd(1'b0, "midfill_status", 8'h00);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
